// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if
//   Bundles the fetch-side push channel, the decode-side pop channel, the
//   redirect flush and the occupancy count of the fetch/decode instruction
//   queue.
//   master : driven by the fetch/decode pipeline (or a testbench)
//            drives flush, in_valid, in_pc, in_instr, out_ready
//            observes in_ready, out_valid, out_pc, out_instr, count
//   slave  : the queue itself (direction mirror of master)
interface fetch_decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [CW-1:0]   count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Instruction buffer between fetch and decode. Fetch pushes {pc, instr}
//   pairs over a valid/ready handshake, decode pops them in strict FIFO
//   order. Back-pressures fetch when full and discards everything on flush
//   (branch/jump redirect) so no stale instruction reaches decode.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : fetch_decode_queue_if.slave
//            flush               synchronous discard of all entries
//            in_valid/in_ready   push handshake, in_pc/in_instr payload
//            out_valid/out_ready pop handshake, out_pc/out_instr head entry
//            count               entries held, 0..DEPTH
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic in_ready_w;
  logic out_valid_w;
  logic push;
  logic pop;

  // Ready/valid depend on occupancy only, so neither side can form a
  // combinational loop through the other's handshake.
  assign in_ready_w  = (count_q != FULL);
  assign out_valid_w = (count_q != '0);
  assign push        = bus.in_valid  & in_ready_w;
  assign pop         = bus.out_ready & out_valid_w;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  // NOTE: storage is reset here because the head entry reads as zero after
  // reset; flush only rewinds the pointers since out_* are masked when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      // Redirect wins over any same-cycle push or pop.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= bus.in_pc;
        instr_mem[wr_ptr] <= bus.in_instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.out_pc    = '0;
    bus.out_instr = '0;
    if (out_valid_w) begin
      bus.out_pc    = pc_mem[rd_ptr];
      bus.out_instr = instr_mem[rd_ptr];
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue
//   Directed self-checking bench for fetch_decode_queue (DEPTH=4, XLEN=32).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   that same point, well away from the active edge.
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk;
  logic reset;

  fetch_decode_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
  endtask

  // Push one pair with out_ready low; leaves in_valid low afterwards.
  task automatic push_pair(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Pop n entries, expecting pcs start, start+4, ...
  task automatic drain(input string tag, input int n, input logic [31:0] start);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_pc"}, bus.out_pc, start + 32'(4 * i));
      step();
    end
    bus.out_ready = 1'b0;
    check({tag, "_empty"}, bus.out_valid, 1'b0);
  endtask

  function automatic logic [31:0] instr_of(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  initial begin
    int mc, sent, recv, cyc;
    logic do_push, do_pop;

    idle_inputs();
    reset = 1'b0;
    #12;
    // Power-on reset state.
    check("rst0_count", bus.count, 0);
    check("rst0_out_valid", bus.out_valid, 1'b0);
    check("rst0_in_ready", bus.in_ready, 1'b1);
    check("rst0_out_pc", bus.out_pc, 0);
    check("rst0_out_instr", bus.out_instr, 0);
    reset = 1'b1;
    step();

    // Ordering.
    push_pair(32'h0, 32'h00a00093);
    check("ord_count1", bus.count, 1);
    push_pair(32'h4, 32'h00b00113);
    push_pair(32'h8, 32'h00c00193);
    check("ord_count3", bus.count, 3);
    bus.out_ready = 1'b1;
    check("ord_head0_instr", bus.out_instr, 32'h00a00093);
    check("ord_head0_pc", bus.out_pc, 32'h0);
    step();
    check("ord_count2", bus.count, 2);
    check("ord_head1_instr", bus.out_instr, 32'h00b00113);
    check("ord_head1_pc", bus.out_pc, 32'h4);
    step();
    check("ord_count1b", bus.count, 1);
    check("ord_head2_instr", bus.out_instr, 32'h00c00193);
    check("ord_head2_pc", bus.out_pc, 32'h8);
    step();
    bus.out_ready = 1'b0;
    check("ord_count0", bus.count, 0);
    check("ord_out_valid", bus.out_valid, 1'b0);
    check("ord_out_instr0", bus.out_instr, 0);

    // Pop on empty must not underflow.
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("empty_pop_count", bus.count, 0);

    // Full.
    for (int i = 0; i < 4; i++) push_pair(32'(4 * i), instr_of(i));
    check("full_count", bus.count, 4);
    check("full_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h10;
    bus.in_instr = instr_of(4);
    step();
    check("full_hold_count", bus.count, 4);
    check("full_hold_head", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("full_nobypass_count", bus.count, 3);
    check("full_after_pop_head", bus.out_pc, 32'h4);
    check("full_after_pop_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check("full_refill_count", bus.count, 4);
    drain("full_drain", 4, 32'h4);

    // Simultaneous push & pop at count=2.
    push_pair(32'h0, instr_of(0));
    push_pair(32'h4, instr_of(1));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_pc    = 32'(8 + 4 * i);
      bus.in_instr = instr_of(i + 2);
      check("sim_count", bus.count, 2);
      check("sim_head_pc", bus.out_pc, 32'(4 * i));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("sim_end_count", bus.count, 2);
    drain("sim_drain", 2, 32'h28);

    // Wrap: 3*DEPTH pcs with random decode stalls, checked against a count model.
    mc = 0; sent = 0; recv = 0; cyc = 0;
    while (recv < 3 * DEPTH && cyc < 500) begin
      check("wrap_in_ready", bus.in_ready, (mc != DEPTH));
      check("wrap_out_valid", bus.out_valid, (mc != 0));
      check("wrap_count", bus.count, mc);
      if (mc != 0) begin
        check("wrap_pc", bus.out_pc, 32'(4 * recv));
        check("wrap_instr", bus.out_instr, instr_of(recv));
      end
      bus.in_valid  = (sent < 3 * DEPTH);
      bus.in_pc     = 32'(4 * sent);
      bus.in_instr  = instr_of(sent);
      bus.out_ready = 1'($urandom_range(0, 1));
      do_push = bus.in_valid && (mc != DEPTH);
      do_pop  = bus.out_ready && (mc != 0);
      step();
      if (do_push) begin sent++; mc++; end
      if (do_pop)  begin recv++; mc--; end
      cyc++;
    end
    idle_inputs();
    check("wrap_all_received", recv, 3 * DEPTH);
    check("wrap_end_count", bus.count, 0);

    // Flush with same-cycle push and pop.
    push_pair(32'h0, instr_of(0));
    push_pair(32'h4, instr_of(1));
    push_pair(32'h8, instr_of(2));
    check("flush_pre_count", bus.count, 3);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h30;
    bus.out_ready = 1'b1;
    step();
    idle_inputs();
    check("flush_count", bus.count, 0);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_out_pc", bus.out_pc, 0);
    push_pair(32'h40, 32'h00100093);
    check("flush_next_valid", bus.out_valid, 1'b1);
    check("flush_next_pc", bus.out_pc, 32'h40);
    check("flush_next_instr", bus.out_instr, 32'h00100093);
    check("flush_next_count", bus.count, 1);

    // Asynchronous reset mid-run with count=3, flush held meanwhile.
    push_pair(32'h44, instr_of(5));
    push_pair(32'h48, instr_of(6));
    check("rst_pre_count", bus.count, 3);
    reset = 1'b0;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_instr", bus.out_instr, 0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h50;
    step();
    check("rst_hold_count", bus.count, 0);
    idle_inputs();
    #2;
    reset = 1'b1;
    push_pair(32'h60, instr_of(7));
    check("rst_resume_pc", bus.out_pc, 32'h60);
    check("rst_resume_count", bus.count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
